// File: rtl/count_mon_pkg.sv
// Shared defaults and snapshot layout for the counter capture monitor.
package count_mon_pkg;

    localparam int unsigned DEFAULT_CNT_W   = 4;
    localparam int unsigned DEFAULT_EPOCH_W = 4;
    localparam int unsigned DEFAULT_DEPTH   = 4;

    typedef struct packed {
        logic [DEFAULT_EPOCH_W-1:0] epoch;
        logic [DEFAULT_CNT_W-1:0]   count;
    } snap_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; level is kept separately so that
// full and empty stay unambiguous when the pointers coincide.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    // When full with push and pop together, wptr equals rptr: the departing
    // head's slot is reused for the new tail entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            if (push) begin
                mem_q[wptr_q] <= wdata;
            end
        end
    end

    assign rdata = mem_q[rptr_q];
    assign level = level_q;
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

endmodule

// File: rtl/count_capture_fifo.sv
// Monitors an upstream counter, tracks wrap epochs and queues {epoch, count}
// snapshots on a capture strobe for a valid/ready consumer.
module count_capture_fifo
    import count_mon_pkg::*;
#(
    parameter int unsigned CNT_W   = DEFAULT_CNT_W,
    parameter int unsigned EPOCH_W = DEFAULT_EPOCH_W,
    parameter int unsigned DEPTH   = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CNT_W-1:0]           cnt_in,
    input  logic                       capture,
    input  logic                       out_ready,
    input  logic                       clr_ovf,
    output logic                       out_valid,
    output logic [EPOCH_W+CNT_W-1:0]   out_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int unsigned DW = EPOCH_W + CNT_W;

    logic [CNT_W-1:0]   cnt_q;
    logic [EPOCH_W-1:0] epoch_q, epoch_nxt;
    logic               ovf_q, ovf_d;
    logic               wrap, push, pop, drop;
    logic [DW-1:0]      snap;

    assign wrap      = (cnt_q == '1) && (cnt_in == '0);
    assign epoch_nxt = epoch_q + EPOCH_W'(wrap);
    assign snap      = {epoch_nxt, cnt_in};

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push      = capture && (!full || pop);
    assign drop      = capture && full && !pop;

    // A drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            epoch_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_in;
            epoch_q <= epoch_nxt;
            ovf_q   <= ovf_d;
        end
    end

    assign overflow = ovf_q;

    sync_fifo #(
        .WIDTH (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (snap),
        .rdata (out_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

endmodule

// File: doc/count_capture_fifo.md
# count_capture_fifo

Synchronous monitor that sits directly downstream of the 4-bit ripple counter. It samples the counter value every clock, tracks counter wrap-arounds in an epoch register, and pushes timestamped snapshots `{epoch, count}` into a small FIFO on a capture strobe. A consumer drains the FIFO through a valid/ready handshake.

## Interface
- `CNT_W`, 4, width of the monitored counter value.
- `EPOCH_W`, 4, width of the wrap (epoch) counter.
- `DEPTH`, 4, FIFO entries; must be a power of two and at least 2.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
- `cnt_in`  in  CNT_W  counter value from the upstream counter's `Q` output.
- `capture`  in  1  push a snapshot this cycle.
- `out_ready`  in  1  consumer accepts the head entry.
- `clr_ovf`  in  1  clears the sticky overflow flag.
- `out_valid`  out  1  FIFO is not empty.
- `out_data`  out  EPOCH_W+CNT_W  head entry `{epoch, count}`; epoch occupies the MSBs.
- `full`  out  1  level == DEPTH.
- `empty`  out  1  level == 0.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; at least one capture was dropped.

## Operation
- `cnt_q` is a registered copy of `cnt_in`, updated every cycle.
- Wrap is detected when `cnt_q == 2^CNT_W-1` and `cnt_in == 0`.
- On wrap, `epoch` increments modulo `2^EPOCH_W`; it rolls over silently from all-ones to 0.
- Any other transition, including a non-consecutive jump, does not change `epoch`.
- Snapshot value is `{epoch_nxt, cnt_in}`, where `epoch_nxt` already includes a wrap detected in the same cycle.
  - Example: a capture in the 15→0 cycle with `epoch=2` stores `{3, 0}`.
- Push accepted when `capture && (!full || pop)`.
- Pop happens when `out_valid && out_ready`.
- Simultaneous push and pop:
  - When not empty: `level` is unchanged; the head advances and the new entry is written at the tail.
  - When empty: `pop` is 0, so the push alone is accepted.
- Full with no pop: capture is dropped, FIFO contents are untouched, and `overflow` is set.
- `overflow` stays set until `clr_ovf`. If a drop and `clr_ovf` occur in the same cycle, set wins.
- `out_ready` while empty has no effect.
- Pointer wrap: read and write pointers are `$clog2(DEPTH)` bits and wrap naturally. `level` is tracked separately so full and empty are never ambiguous.

## Timing
- Reset values: `cnt_q=0`, `epoch=0`, pointers 0, `level=0`, `empty=1`, `full=0`, `out_valid=0`, `overflow=0`, `out_data=0`.
- Reset asserted mid-operation discards all entries and the epoch on that edge. `capture` in the same cycle is ignored.
- First cycle after reset: `cnt_q=0`, so no wrap is possible until the counter has reached all-ones.
- Push latency is 1: a capture at edge N is visible as `out_valid=1` with that data after edge N. The FIFO is first-word fall-through with no extra read cycle.
- Pop latency is 1: the head advances on the edge where `out_valid && out_ready`. The next entry, if any, is visible immediately after that edge.
- `out_data` is driven from the registered storage array; there is no combinational path from `capture` or `cnt_in`.
- `full`, `empty` and `out_valid` are registered or decoded from registered `level` only.

## Structure
- Package `count_mon_pkg` holds:
  - default `CNT_W`, `EPOCH_W` and `DEPTH` constants;
  - snapshot typedef `snap_t` as a packed `{epoch, count}`.
- Sub-module `sync_fifo` (parameterised width and depth, push/pop/full/empty/level) holds the storage.
- The top level contains wrap detection, the epoch register, the overflow flag and the push/pop logic.

## Test plan
- **Reset then single capture:** reset for 2 cycles, `cnt_in=5`, `capture` for 1 cycle → `out_valid=1` next cycle, `out_data=8'h05`, `level=1`.
- **Wrap capture:** `cnt_in` steps 14, 15, 0 with `capture` in the 0 cycle → `out_data=8'h10`. Drive 16 further full wraps, then check the `epoch` rollover to 1 in the stored entry.
- **Fill and overflow:**
  - 5 consecutive captures of values 1–5 with `out_ready=0` → `full=1`, `level=4`, `overflow=1`;
  - drain order is 1, 2, 3, 4; value 5 is lost.
- **Simultaneous push/pop when full:** `capture` with `cnt_in=9` while `out_ready=1` → `level` stays 4, `overflow` is not set, and 9 emerges last.
- **Overflow clear race:** drop and `clr_ovf` in the same cycle → `overflow=1`. Then `clr_ovf` alone → `overflow=0`.
- **Reset mid-operation:** FIFO holding 3 entries and `epoch=2`; assert `reset` with `capture=1` → next cycle `empty=1`, `level=0`, and a subsequent capture stores epoch 0.
